// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants, state type and lane helpers for the dispatcher
package demux_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // One-hot lane vector for a lane index
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_LANES-1:0] one;
    one = {{(NUM_LANES-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/demux_rr_dispatcher_if.sv
// rtl/demux_rr_dispatcher_if.sv - producer/consumer handshake bundle for the dispatcher
interface demux_rr_dispatcher_if #(
  parameter int DATA_W = 8
) ();
  import demux_pkg::*;

  logic                 in_valid;
  logic [DATA_W-1:0]    in_data;
  logic                 in_ready;
  logic [NUM_LANES-1:0] out_valid;
  logic [DATA_W-1:0]    out_data;
  logic [NUM_LANES-1:0] out_ready;

  // Producer and lane consumers
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Dispatcher
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - round-robin pick of the next masked lane after ptr
module rr_pick8
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]     ptr,
  input  logic [NUM_LANES-1:0] mask,
  output logic                 found,
  output logic [SEL_W-1:0]     idx
);

  logic [SEL_W-1:0] cand;

  // Scan from ptr+8 (== ptr) down to ptr+1 so the nearest lane after ptr wins last
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NUM_LANES; k >= 1; k--) begin
      cand = ptr + k[SEL_W-1:0];
      if (mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// rtl/demux_rr_dispatcher.sv - round-robin 1-to-8 stream dispatcher with a held output register
module demux_rr_dispatcher
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_LANES-1:0] lane_mask,
  output logic [SEL_W-1:0]     sel,
  output logic                 busy,
  demux_rr_dispatcher_if.slave bus
);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_LANES-1:0] out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             can_load;
  logic             in_hs;
  logic             out_hs;

  rr_pick8 u_pick (
    .ptr   (ptr_q),
    .mask  (lane_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Handshake qualification; a pending lane frees the slot in the same cycle it drains
  always_comb begin
    out_hs   = out_valid_q[sel_q] & bus.out_ready[sel_q];
    can_load = en & pick_found & ((state_q == IDLE) | bus.out_ready[sel_q]);
    in_hs    = bus.in_valid & can_load;
  end

  // Next-state: a new load wins over a plain drain, giving back-to-back transfers
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_hs) begin
      out_data_d  = bus.in_data;
      sel_d       = pick_idx;
      ptr_d       = pick_idx;
      out_valid_d = lane_onehot(pick_idx);
      state_d     = SEND;
    end else if (out_hs) begin
      out_valid_d = '0;
      state_d     = IDLE;
    end
  end

  // State, pointer and data registers; ptr resets to the last lane so lane 0 goes first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= SEL_W'(NUM_LANES - 1);
      sel_q       <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Output drive
  always_comb begin
    bus.in_ready  = can_load;
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    sel           = sel_q;
    busy          = |out_valid_q;
  end

endmodule
